// File: rtl/mpx_pkg.sv
// Shared types and helpers for the FM-stereo multiplex composer: FSM states,
// multiplier operand widths and the signed saturation helper.
package mpx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMulP,
    StMulD,
    StSum,
    StMulF,
    StOut
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of the signed A operand (audio or carrier sample).
  function automatic int unsigned maw_f(input int unsigned dw, input int unsigned sw);
    return max2(dw, sw);
  endfunction

  // Width of the signed B operand: carrier sample or zero-extended gain.
  function automatic int unsigned mbw_f(input int unsigned sw, input int unsigned kpw,
                                        input int unsigned kfw);
    return max2(sw, max2(kpw + 1, kfw + 1));
  endfunction

  // Clamp x into the w-bit two's-complement range.
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] x,
                                                input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/mpx_composer_seq_mult.sv
// Signed shift-add multiplier: one load cycle on start, then MBW shift-add cycles.
// ready is high during the final shift-add, so product is valid after that edge.
module seq_mult_sm #(
  parameter int unsigned MAW = 18,
  parameter int unsigned MBW = 9
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [MAW-1:0]      a,
  input  logic        [MBW-1:0]      b,
  output logic                       ready,
  output logic signed [MAW+MBW-1:0]  product
);

  localparam int unsigned PW = MAW + MBW;
  localparam int unsigned CW = $clog2(MBW + 1);

  logic signed [PW-1:0] a_q;
  logic signed [PW-1:0] acc_q;
  logic        [MBW-1:0] b_q;
  logic        [CW-1:0]  cnt_q;
  logic                  last;

  assign last    = (cnt_q == CW'(1));
  assign ready   = last;
  assign product = acc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q   <= '0;
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (start) begin
      a_q   <= PW'(a);
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= CW'(MBW);
    end else if (cnt_q != '0) begin
      // The B sign bit carries negative weight in two's complement.
      if (b_q[0]) acc_q <= last ? (acc_q - a_q) : (acc_q + a_q);
      a_q   <= a_q <<< 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/mpx_composer_seq.sv
// FM-stereo MPX composer: in_sum + Kp*sin19 + in_diff*sin38, saturated, scaled by Kf.
// Define MPX_ROUND_EN to round half-up on the L-R and final right shifts.
module mpx_composer_seq
  import mpx_pkg::*;
#(
  parameter int unsigned DW     = 18,
  parameter int unsigned SW     = 8,
  parameter int unsigned KPW    = 4,
  parameter int unsigned KFW    = 8,
  parameter int unsigned OW     = 24,
  parameter int unsigned PSHIFT = 2,
  parameter int unsigned RSHIFT = 8,
  parameter int unsigned FSHIFT = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clken,
  input  logic signed [DW-1:0] in_sum,
  input  logic signed [DW-1:0] in_diff,
  input  logic signed [SW-1:0] sin19,
  input  logic signed [SW-1:0] sin38,
  input  logic [KPW-1:0]       kp,
  input  logic [KFW-1:0]       kf,
  output logic signed [OW-1:0] fm_out,
  output logic                 fm_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 sat
);

  localparam int unsigned MAW = maw_f(DW, SW);
  localparam int unsigned MBW = mbw_f(SW, KPW, KFW);
  localparam int unsigned PW  = MAW + MBW;
  localparam int unsigned WW  = PW + PSHIFT + 2;

  state_e state_q;
  logic   first_q, busy_q, overrun_q, fm_valid_q, sat_q, sat_s_q;
  logic signed [DW-1:0] sum_r, diff_r, s_q;
  logic signed [SW-1:0] s19_r, s38_r;
  logic [KPW-1:0]       kp_r;
  logic [KFW-1:0]       kf_r;
  logic signed [WW-1:0] pilot_q;
  logic signed [OW-1:0] fm_out_q;

  logic                  m_start, m_ready;
  logic signed [MAW-1:0] m_a;
  logic        [MBW-1:0] m_b;
  logic signed [PW-1:0]  m_p;

  logic signed [WW-1:0] prod_w, pilot_w, diff_w, s_w, o_w;
  logic signed [63:0]   s_sat, o_sat;
  logic                 s_clamp, o_clamp;

  seq_mult_sm #(
    .MAW(MAW),
    .MBW(MBW)
  ) u_mult (
    .clock  (clock),
    .reset  (reset),
    .start  (m_start),
    .a      (m_a),
    .b      (m_b),
    .ready  (m_ready),
    .product(m_p)
  );

  always_comb begin
    m_a     = '0;
    m_b     = '0;
    m_start = first_q && (state_q inside {StMulP, StMulD, StMulF});
    unique case (state_q)
      StMulP:  begin m_a = MAW'(s19_r);  m_b = MBW'({1'b0, kp_r}); end
      StMulD:  begin m_a = MAW'(diff_r); m_b = MBW'(s38_r);        end
      StMulF:  begin m_a = MAW'(s_q);    m_b = MBW'({1'b0, kf_r}); end
      default: ;
    endcase
  end

  // The held product is consumed in the first cycle of the following state.
  always_comb begin
    prod_w  = WW'(m_p);
    pilot_w = prod_w <<< PSHIFT;
`ifdef MPX_ROUND_EN
    diff_w  = (prod_w + (WW'(1) <<< (RSHIFT - 1))) >>> RSHIFT;
    o_w     = (prod_w + (WW'(1) <<< (FSHIFT - 1))) >>> FSHIFT;
`else
    diff_w  = prod_w >>> RSHIFT;
    o_w     = prod_w >>> FSHIFT;
`endif
    s_w     = WW'(sum_r) + pilot_q + diff_w;
    s_sat   = sat_fn(64'(s_w), DW);
    s_clamp = (s_sat != 64'(s_w));
    o_sat   = sat_fn(64'(o_w), OW);
    o_clamp = (o_sat != 64'(o_w));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      fm_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      sat_s_q    <= 1'b0;
      sum_r      <= '0;
      diff_r     <= '0;
      s19_r      <= '0;
      s38_r      <= '0;
      kp_r       <= '0;
      kf_r       <= '0;
      s_q        <= '0;
      pilot_q    <= '0;
      fm_out_q   <= '0;
    end else begin
      fm_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= clken && busy_q;
      unique case (state_q)
        // busy_q in StIdle marks a freshly latched sample awaiting launch.
        StIdle: begin
          if (busy_q) begin
            state_q <= StMulP;
            first_q <= 1'b1;
          end else if (clken) begin
            sum_r  <= in_sum;
            diff_r <= in_diff;
            s19_r  <= sin19;
            s38_r  <= sin38;
            kp_r   <= kp;
            kf_r   <= kf;
            busy_q <= 1'b1;
          end
        end
        StMulP: begin
          first_q <= 1'b0;
          if (!first_q && m_ready) begin
            state_q <= StMulD;
            first_q <= 1'b1;
          end
        end
        StMulD: begin
          first_q <= 1'b0;
          if (first_q) pilot_q <= pilot_w;
          if (!first_q && m_ready) state_q <= StSum;
        end
        StSum: begin
          s_q     <= DW'(s_sat);
          sat_s_q <= s_clamp;
          state_q <= StMulF;
          first_q <= 1'b1;
        end
        StMulF: begin
          first_q <= 1'b0;
          if (!first_q && m_ready) state_q <= StOut;
        end
        StOut: begin
          fm_out_q   <= OW'(o_sat);
          fm_valid_q <= 1'b1;
          sat_q      <= sat_s_q | o_clamp;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fm_out   = fm_out_q;
  assign fm_valid = fm_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign sat      = sat_q;

endmodule
